// File: rtl/prefix_adder_16bit.sv
// prefix_adder_16bit: registered 16-bit Kogge-Stone adder, {Cout,S} = A + B + Cin one cycle later
module prefix_adder_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout
);
    logic [15:0] g, p, gg, pp, gn, pn;
    assign g = A & B;
    assign p = A ^ B;
    // Cin is folded into bit 0's generate, so G[i:0] below equals G[i:-1] = c[i+1]
    always_comb begin
        gg = {g[15:1], g[0] | (p[0] & Cin)};
        pp = p;
        gn = gg;
        pn = pp;
        for (int l = 1; l < 16; l = l * 2) begin
            gn = gg;
            pn = pp;
            for (int i = l; i < 16; i++) begin
                gn[i] = gg[i] | (pp[i] & gg[i-l]);
                pn[i] = pp[i] & pp[i-l];
            end
            gg = gn;
            pp = pn;
        end
    end
    always_ff @(posedge clk)
        if (!rst_n) {Cout, S} <= 17'h0;
        else        {Cout, S} <= {gg[15], p ^ {gg[14:0], Cin}};
endmodule

// File: tb/tb_prefix_adder_16bit.sv
// tb_prefix_adder_16bit: directed and random checks of the registered prefix adder against an arithmetic model
module tb_prefix_adder_16bit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] A = 16'h0, B = 16'h0;
    logic        Cin = 1'b0;
    logic [15:0] S;
    logic        Cout;
    int          total = 0, bad = 0;
    logic [16:0] exp_v = 17'h0;
    logic        exp_ok = 1'b0;

    always #5 clk = ~clk;

    prefix_adder_16bit dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin), .S(S), .Cout(Cout));

    // model: what the register must hold after each edge
    always @(posedge clk) begin
        exp_v  <= rst_n ? ({1'b0, A} + {1'b0, B} + {16'h0, Cin}) : 17'h0;
        exp_ok <= 1'b1;
    end

    always @(negedge clk)
        if (exp_ok) begin
            total++;
            if ({Cout, S} !== exp_v) begin
                bad++;
                $display("FAIL model: got {Cout,S}=%h want %h", {Cout, S}, exp_v);
            end
        end

    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic c, input logic r,
                        input logic chk, input logic [16:0] want, input string nm);
        @(negedge clk);
        A = a; B = b; Cin = c; rst_n = r;
        @(posedge clk);
        #1;
        if (chk) begin
            total++;
            if ({Cout, S} !== want) begin
                bad++;
                $display("FAIL %s: got {Cout,S}=%h want %h", nm, {Cout, S}, want);
            end
        end
    endtask

    initial begin
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 17'h00000, "reset1");
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 17'h00000, "reset2");
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1, 17'h1FFFF, "release");
        step(16'h1234, 16'h5678, 1'b0, 1'b1, 1'b1, 17'h068AC, "basic");
        step(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, 17'h10000, "propagate");
        step(16'hAAAA, 16'h5555, 1'b1, 1'b1, 1'b1, 17'h10000, "cin_chain");
        step(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1, 17'h10001, "msb_gen");
        step(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 17'h00000, "zero");
        step(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 17'h00000, "mid_reset");
        step(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, 17'h08000, "after_reset");
        step(16'h00FF, 16'h0F01, 1'b1, 1'b1, 1'b1, 17'h01001, "stream1");
        step(16'hC000, 16'h4000, 1'b0, 1'b1, 1'b1, 17'h10000, "stream2");
        step(16'h0F0F, 16'hF0F0, 1'b0, 1'b1, 1'b1, 17'h0FFFF, "stream3");
        for (int n = 0; n < 10000; n++)
            step(16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 1'b0, 17'h0, "rand");
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
